seven_seg_scanner: RTL

- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Sits directly upstream of the hex-to-segment decoder:
  - drives its 4-bit hex digit and its flash control;
  - drives the per-digit anode enables itself.
- Latches a 16-bit value without tearing, cycles through the digits at a programmable refresh rate, and produces a per-digit blink phase.

---
 rtl/seven_seg_scanner.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Captures a 16-bit value into a shadow register, moves it into the
// display register only at frame start (no tearing), walks the four digit
// slots at REFRESH_DIV clocks each, and produces a per-digit blink phase.
// Every slot begins with one dead-time cycle in which all anodes are off.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (3, 2, 1) are kept dark for the whole
//   frame; digit 0 is always driven. When undefined, no blanking logic exists.
//
// All outputs are registered. Each output register is loaded with the value
// that belongs to the *next* counter state, so outputs and counters move
// together on the same clock edge.

module seven_seg_scanner #(
    parameter int REFRESH_DIV = 50000,  // clocks per digit slot, >= 2
    parameter int BLINK_DIV   = 64      // frames per blink half-period, >= 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Value,
    input  logic        Load,
    input  logic [3:0]  BlinkMask,
    output logic [3:0]  HexVal,
    output logic        flashState,
    output logic [3:0]  An,
    output logic [1:0]  DigitIdx
);

    localparam int SLOT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRAME_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [1:0]         digit_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic               phase_r;
    logic               pending_r;
    logic [15:0]        shadow_r;
    logic [15:0]        display_r;

    // Output registers
    logic [3:0]         hex_r;
    logic               flash_r;
    logic [3:0]         an_r;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic               slot_tc_s;
    logic               frame_start_s;
    logic [SLOT_W-1:0]  slot_next_s;
    logic [1:0]         digit_next_s;
    logic [FRAME_W-1:0] frame_next_s;
    logic               phase_next_s;
    logic               pending_next_s;
    logic [15:0]        shadow_next_s;
    logic [15:0]        display_next_s;
    logic               blanked_next_s;

    logic [3:0]         hex_next_s;
    logic [3:0]         an_sel_s;
    logic [3:0]         an_next_s;
    logic               flash_next_s;

    // Slot/digit/frame counters, blink phase and the shadow/display handoff
    always_comb begin
        slot_tc_s     = (slot_cnt_r == SLOT_LAST);
        frame_start_s = slot_tc_s && (digit_r == 2'd3);

        if (slot_tc_s) begin
            slot_next_s  = {SLOT_W{1'b0}};
            digit_next_s = digit_r + 2'd1;
        end else begin
            slot_next_s  = slot_cnt_r + SLOT_W'(1);
            digit_next_s = digit_r;
        end

        if (frame_start_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_next_s = {FRAME_W{1'b0}};
                phase_next_s = ~phase_r;
            end else begin
                frame_next_s = frame_cnt_r + FRAME_W'(1);
                phase_next_s = phase_r;
            end
        end else begin
            frame_next_s = frame_cnt_r;
            phase_next_s = phase_r;
        end

        // Display takes the shadow as it was before any same-cycle Load,
        // so a Load coinciding with frame start waits for the next frame.
        if (frame_start_s && pending_r) begin
            display_next_s = shadow_r;
        end else begin
            display_next_s = display_r;
        end

        if (Load) begin
            shadow_next_s  = Value;
            pending_next_s = 1'b1;
        end else if (frame_start_s) begin
            shadow_next_s  = shadow_r;
            pending_next_s = 1'b0;
        end else begin
            shadow_next_s  = shadow_r;
            pending_next_s = pending_r;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] blank_r;
    logic [3:0] blank_next_s;

    // Digits 3..1 are blank while they and all higher digits are zero
    function automatic logic [3:0] lzb_mask(input logic [15:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = m[3] && (v[11:8] == 4'h0);
        m[1] = m[2] && (v[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

    // Blank mask is recomputed from the new display value at frame start only
    always_comb begin
        if (frame_start_s) begin
            blank_next_s = lzb_mask(display_next_s);
        end else begin
            blank_next_s = blank_r;
        end
        blanked_next_s = blank_next_s[digit_next_s];
    end

    // Blank mask register, held for a full frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blank_r <= 4'b0000;
        end else begin
            blank_r <= blank_next_s;
        end
    end
`else
    // Every digit is always driven
    always_comb begin
        blanked_next_s = 1'b0;
    end
`endif

    // Output decode for the upcoming counter state
    always_comb begin
        case (digit_next_s)
            2'd0: begin
                hex_next_s = display_next_s[3:0];
                an_sel_s   = 4'b1110;
            end
            2'd1: begin
                hex_next_s = display_next_s[7:4];
                an_sel_s   = 4'b1101;
            end
            2'd2: begin
                hex_next_s = display_next_s[11:8];
                an_sel_s   = 4'b1011;
            end
            2'd3: begin
                hex_next_s = display_next_s[15:12];
                an_sel_s   = 4'b0111;
            end
            default: begin
                hex_next_s = 4'h0;
                an_sel_s   = 4'b1111;
            end
        endcase

        // First cycle of each slot is dead time; blanked digits stay dark
        if ((slot_next_s == {SLOT_W{1'b0}}) || blanked_next_s) begin
            an_next_s = 4'b1111;
        end else begin
            an_next_s = an_sel_s;
        end

        if (blanked_next_s) begin
            flash_next_s = 1'b0;
        end else begin
            flash_next_s = phase_next_s & BlinkMask[digit_next_s];
        end
    end

    // Counter, blink and value-holding state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_cnt_r  <= {SLOT_W{1'b0}};
            digit_r     <= 2'd0;
            frame_cnt_r <= {FRAME_W{1'b0}};
            phase_r     <= 1'b0;
            pending_r   <= 1'b0;
            shadow_r    <= 16'h0000;
            display_r   <= 16'h0000;
        end else begin
            slot_cnt_r  <= slot_next_s;
            digit_r     <= digit_next_s;
            frame_cnt_r <= frame_next_s;
            phase_r     <= phase_next_s;
            pending_r   <= pending_next_s;
            shadow_r    <= shadow_next_s;
            display_r   <= display_next_s;
        end
    end

    // Registered outputs toward the decoder and anode drivers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hex_r   <= 4'h0;
            flash_r <= 1'b0;
            an_r    <= 4'b1111;
        end else begin
            hex_r   <= hex_next_s;
            flash_r <= flash_next_s;
            an_r    <= an_next_s;
        end
    end

    assign HexVal     = hex_r;
    assign flashState = flash_r;
    assign An         = an_r;
    assign DigitIdx   = digit_r;

endmodule
